cic_comb_chain: RTL and testbench

//  Multi-stage, multi-channel CIC comb section with a parametrised differential delay.
//  It sits after the decimator in the receive chain and takes the place of a chain of

---
 rtl/cic_comb_chain.sv | 91 +++++++++
 tb/tb_cic_comb_chain.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cic_comb_chain.sv
// cic_comb_chain: multi-stage, multi-channel CIC comb with differential delay.
// Channels are time-interleaved through one shared fixed-latency pipeline.
module cic_comb_chain #(
  parameter int WIDTH      = 64,
  parameter int STAGES     = 5,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 2,
  parameter int CHAN_W     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bypass,
  input  logic              in_strobe,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_strobe,
  output logic [CHAN_W-1:0] out_chan,
  output logic [WIDTH-1:0]  out_data
);

  localparam logic [CHAN_W:0] NCH = (CHAN_W+1)'(CHANNELS);

  logic [STAGES-1:0] p_v;
  logic [STAGES-1:0] p_b;
  logic [CHAN_W-1:0] p_c [STAGES];
  logic [WIDTH-1:0]  p_x [STAGES];
  logic [WIDTH-1:0]  p_r [STAGES];
  logic [WIDTH-1:0]  y   [STAGES];
  logic [WIDTH-1:0]  h   [STAGES][CHANNELS][DIFF_DELAY];
  logic              accept;

  assign accept = in_strobe && ({1'b0, in_chan} < NCH);

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      y[k] = p_x[k] - h[k][p_c[k]][DIFF_DELAY-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_v        <= '0;
      p_b        <= '0;
      out_strobe <= 1'b0;
      out_chan   <= '0;
      out_data   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        p_c[k] <= '0;
        p_x[k] <= '0;
        p_r[k] <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          for (int i = 0; i < DIFF_DELAY; i++) begin
            h[k][c][i] <= '0;
          end
        end
      end
    end else begin
      p_v[0] <= accept;
      if (accept) begin
        p_c[0] <= in_chan;
        p_b[0] <= bypass;
        p_x[0] <= in_data;
        p_r[0] <= in_data;
      end
      // histories always take the comb-path input, even when bypassed
      for (int k = 0; k < STAGES; k++) begin
        if (p_v[k]) begin
          for (int i = DIFF_DELAY-1; i > 0; i--) begin
            h[k][p_c[k]][i] <= h[k][p_c[k]][i-1];
          end
          h[k][p_c[k]][0] <= p_x[k];
        end
      end
      for (int k = 0; k < STAGES-1; k++) begin
        p_v[k+1] <= p_v[k];
        if (p_v[k]) begin
          p_c[k+1] <= p_c[k];
          p_b[k+1] <= p_b[k];
          p_x[k+1] <= y[k];
          p_r[k+1] <= p_r[k];
        end
      end
      out_strobe <= p_v[STAGES-1];
      if (p_v[STAGES-1]) begin
        out_chan <= p_c[STAGES-1];
        out_data <= p_b[STAGES-1] ? p_r[STAGES-1] : y[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain: random + directed check of the comb chain against
// a closed-form binomial model y[n] = sum (-1)^j C(N,j) x[n-jM].
module tb_cic_comb_chain;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int M  = 2;
  localparam int CH = 3;
  localparam int CW = 2;
  localparam int L  = N*M;

  logic          clock = 1'b0;
  logic          reset, bypass, in_strobe;
  logic [CW-1:0] in_chan;
  logic [W-1:0]  in_data;
  logic          out_strobe;
  logic [CW-1:0] out_chan;
  logic [W-1:0]  out_data;

  cic_comb_chain #(
    .WIDTH(W), .STAGES(N), .DIFF_DELAY(M),
    .CHANNELS(CH), .CHAN_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .bypass(bypass),
    .in_strobe(in_strobe), .in_chan(in_chan), .in_data(in_data),
    .out_strobe(out_strobe), .out_chan(out_chan), .out_data(out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           due;
    logic [CW-1:0] c;
    logic [W-1:0]  d;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] xh [CH][L];
  logic [W-1:0] last_d;
  logic [CW-1:0] last_c;
  logic         rst_seen;
  int           edge_no = 0;
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               tag, got, want, edge_no);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  function automatic logic [W-1:0] comb_ref(input int c,
                                            input logic [W-1:0] x);
    int acc;
    acc = int'(x);
    for (int j = 1; j <= N; j++) begin
      acc += ((j % 2) ? -1 : 1) * binom(N, j) * int'(xh[c][j*M-1]);
    end
    return acc[W-1:0];
  endfunction

  task automatic model_edge(input logic r, input logic s,
                            input logic [CW-1:0] c,
                            input logic [W-1:0] d, input logic b);
    exp_t e;
    rst_seen = r;
    if (r) begin
      q.delete();
      for (int i = 0; i < CH; i++)
        for (int j = 0; j < L; j++) xh[i][j] = '0;
      last_d = '0;
      last_c = '0;
    end else if (s && int'(c) < CH) begin
      e.due = edge_no + N;
      e.c   = c;
      e.d   = b ? d : comb_ref(int'(c), d);
      q.push_back(e);
      for (int j = L-1; j > 0; j--) xh[c][j] = xh[c][j-1];
      xh[c][0] = d;
    end
  endtask

  task automatic check_out();
    if (rst_seen) begin
      chk("rst_strobe", 32'(out_strobe), 32'd0);
      chk("rst_chan", 32'(out_chan), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
    end else if (q.size() > 0 && q[0].due == edge_no) begin
      chk("strobe", 32'(out_strobe), 32'd1);
      chk("chan", 32'(out_chan), 32'(q[0].c));
      chk("data", 32'(out_data), 32'(q[0].d));
      last_d = q[0].d;
      last_c = q[0].c;
      void'(q.pop_front());
    end else begin
      chk("idle_strobe", 32'(out_strobe), 32'd0);
      chk("hold_chan", 32'(out_chan), 32'(last_c));
      chk("hold_data", 32'(out_data), 32'(last_d));
    end
  endtask

  task automatic tick(input logic r, input logic s,
                      input logic [CW-1:0] c,
                      input logic [W-1:0] d, input logic b);
    reset     = r;
    in_strobe = s;
    in_chan   = c;
    in_data   = d;
    bypass    = b;
    @(posedge clock);
    edge_no++;
    model_edge(r, s, c, d, b);
    @(negedge clock);
    check_out();
  endtask

  initial begin
    reset = 1'b1; bypass = 1'b0; in_strobe = 1'b0;
    in_chan = '0; in_data = '0;
    last_d = '0; last_c = '0; rst_seen = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 16'h55, 0);

    // impulse on channel 0
    tick(0, 1, 0, 16'd1, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 16'd0, 0);

    // interleaved ramp / constant, back-to-back strobes
    for (int i = 0; i < 24; i++) begin
      tick(0, 1, 1, W'(i), 0);
      tick(0, 1, 2, 16'd100, 0);
    end

    // bypass then normal on same channel
    tick(0, 1, 0, 16'd3, 1);
    tick(0, 1, 0, 16'd3, 1);
    tick(0, 1, 0, 16'd3, 0);
    // invalid channel tag
    tick(0, 1, 3, 16'h1234, 0);
    tick(0, 1, 0, 16'd3, 0);

    // wrap extremes
    tick(0, 1, 1, 16'h8000, 0);
    tick(0, 1, 1, 16'h7fff, 0);

    for (int i = 0; i < 300; i++) begin
      tick(0, ($urandom_range(3) != 0), CW'($urandom_range(3)),
           W'($urandom), ($urandom_range(3) == 0));
    end

    // reset one clock after a strobe: in-flight samples vanish
    tick(0, 1, 2, 16'h0777, 0);
    tick(1, 1, 2, 16'h0999, 0);
    tick(1, 0, 0, 16'd0, 0);
    tick(0, 1, 2, 16'd1, 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 2, 16'd0, 0);

    for (int i = 0; i < N + 3; i++) tick(0, 0, 0, 16'd0, 0);
    chk("drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
